// File: rtl/dmem_banked_if.sv
// Load/store bus between the core and dmem_banked. The memory takes the slave modport.
interface dmem_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int LANES = DATA_W / 8;

  logic              clr;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              err;

  modport master (
    output clr, req, we, addr, wdata, be,
    input  rdata, rvalid, busy, err
  );

  modport slave (
    input  clr, req, we, addr, wdata, be,
    output rdata, rvalid, busy, err
  );
endinterface

// File: rtl/dmem_banked.sv
// Byte-writable data memory with a two-stage registered read and a sequential clear sweep.
// Optional per-lane parity is enabled by defining DMEM_ECC_EN.
module dmem_banked #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  dmem_banked_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              busy_q;
  logic              rvalid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pend_rd_q;
  logic              pend_oor_q;
  logic              pend_err_q;
  logic [DATA_W-1:0] rd_word_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              clr_wr;
  logic              acc_ok;
  logic              wr_en;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [LANES-1:0]  wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              par_fail;

  assign in_range = (32'(bus.addr) < 32'(DEPTH));
  assign clr_wr   = rst && (state_q == ST_CLEAR);
  // clr wins over a same-cycle req; the req is simply dropped.
  assign acc_ok   = rst && (state_q == ST_IDLE) && !bus.clr && bus.req;
  assign wr_en    = clr_wr || (acc_ok && bus.we && in_range);
  assign rd_en    = acc_ok && !bus.we && in_range;
  assign rd_idx   = bus.addr[IDX_W-1:0];
  assign wr_idx   = clr_wr ? clr_idx_q[IDX_W-1:0] : rd_idx;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign wr_mask[gi]          = clr_wr || bus.be[gi];
      assign wr_data[gi*8 +: 8]   = clr_wr ? 8'h00 : bus.wdata[gi*8 +: 8];
    end
  endgenerate

  // No reset on the array or its read register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) rd_word_q <= mem[rd_idx];
  end

`ifdef DMEM_ECC_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] wr_par;
  logic [LANES-1:0] rd_par_q;
  logic [LANES-1:0] rd_par_calc;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_par
      assign wr_par[gi]      = ^wr_data[gi*8 +: 8];
      assign rd_par_calc[gi] = ^rd_word_q[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) par_mem[wr_idx][i] <= wr_par[i];
      end
    end
    if (rd_en) rd_par_q <= par_mem[rd_idx];
  end

  assign par_fail = |(rd_par_calc ^ rd_par_q);
`else
  assign par_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      busy_q     <= 1'b1;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      pend_rd_q  <= 1'b0;
      pend_oor_q <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      // Second stage: the accepted access reports one edge after acceptance.
      pend_rd_q  <= acc_ok && !bus.we;
      pend_oor_q <= !in_range;
      pend_err_q <= acc_ok && !in_range;
      rvalid_q   <= pend_rd_q;
      err_q      <= pend_err_q || (pend_rd_q && !pend_oor_q && par_fail);
      if (pend_rd_q) rdata_q <= pend_oor_q ? '0 : rd_word_q;

      case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.clr) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;
endmodule
